fifo_width_packer: RTL and testbench
====================================

// Module: fifo_width_packer
// PURPOSE
//  Upsizing stage that drains a narrow depth-1 FIFO (EMPTY_N/D_OUT/DEQ side) and
//  packs RATIO consecutive items into one wide word, enqueued into a downstream
//  FIFO (FULL_N/ENQ side). IN_LAST closes a partial word early. Sits between the
//  narrow ingress FIFO and the wide-datapath FIFO of a stream.
// PARAMETERS
//  inWidth   8  width of one narrow item
//  ratio     4  items per wide word; legal 2..16
//  cntWidth  3  width of OUT_CNT; must satisfy 2**cntWidth > ratio
//  outWidth  inWidth*ratio (localparam) wide word width
// PORTS
//  CLK         in   1          clock, all logic on posedge
//  RST_N       in   1          reset, synchronous, active-low
//  CLR         in   1          synchronous flush, same effect as reset
//  IN_D        in   inWidth    narrow item from upstream FIFO D_OUT
//  IN_LAST     in   1          item is last of message; travels with IN_D
//  IN_EMPTY_N  in   1          upstream has an item
//  IN_DEQ      out  1          consume IN_D/IN_LAST this cycle
//  OUT_D       out  outWidth   packed word; lane k = bits [k*inWidth +: inWidth]
//  OUT_CNT     out  cntWidth   number of valid lanes in OUT_D, 1..ratio
//  OUT_LAST    out  1          word closes a message
//  OUT_FULL_N  in   1          downstream can accept
//  OUT_ENQ     out  1          write OUT_D/OUT_CNT/OUT_LAST downstream
// BEHAVIOUR
//  - State: lane counter idx (0..ratio-1), accumulator acc[outWidth-inWidth-1:0],
//    output holding reg {out_d,out_cnt,out_last} plus out_valid.
//  - Reset/CLR: idx=0, acc=0, out_valid=0; so IN_DEQ=0, OUT_ENQ=0 during reset;
//    OUT_D=0, OUT_CNT=0, OUT_LAST=0. CLR beats any same-cycle DEQ/ENQ.
//  - OUT_ENQ = out_valid & OUT_FULL_N (never enqueue into a full FIFO).
//  - close = (idx==ratio-1) | IN_LAST.  drain = OUT_ENQ.
//  - IN_DEQ = IN_EMPTY_N & (!close | !out_valid | drain). Non-closing items
//    never stall; closing items wait for a free/draining holding reg.
//  - On IN_DEQ & !close: lane idx of acc <= IN_D; idx <= idx+1.
//  - On IN_DEQ & close: out_d <= {zero-filled upper lanes, IN_D at lane idx,
//    acc lanes 0..idx-1}; out_cnt <= idx+1; out_last <= IN_LAST; out_valid <= 1;
//    idx <= 0; acc <= 0. Lanes above idx are 0, never stale data.
//  - drain without new close: out_valid <= 0. Drain+close same cycle: out_valid
//    stays 1 with new contents (back-to-back words, 1 narrow item/cycle sustained).
//  - Latency: closing item dequeued in cycle N -> OUT_ENQ earliest in cycle N+1.
//  - OUT_FULL_N low: holding reg keeps its value; filling of the next word
//    continues up to lane ratio-2, then IN_DEQ drops.
//  - IN_LAST at idx==ratio-1: full word, out_cnt=ratio, out_last=1.
//  - IN_EMPTY_N low: no state change apart from draining.
//  - Sim-only check (translate_off): warn if IN_DEQ & !IN_EMPTY_N or
//    OUT_ENQ & !OUT_FULL_N; never fires in a correct design.
// STRUCTURE
//  - No shared package; outWidth and lane math are localparams in this file.
//  - One sub-module is natural: pack_out_reg, a 1-entry holding register with
//    load/drain/clr and valid flag (outWidth+cntWidth+1 bits).
//  - Counter/accumulator and IN_DEQ logic stay in the top module.
// TESTING
//  1 Reset: RST_N=0 3 cycles with IN_EMPTY_N=1 -> IN_DEQ=0, OUT_ENQ=0, OUT_CNT=0.
//  2 Full word: items 11,22,33,44 one per cycle, OUT_FULL_N=1 -> one ENQ,
//    OUT_D=32'h44332211, OUT_CNT=4, OUT_LAST=0, ENQ 1 cycle after item 44.
//  3 Partial: 0xA1,0xB2(IN_LAST) -> OUT_D=32'h0000B2A1, OUT_CNT=2, OUT_LAST=1;
//    next word restarts at lane 0.
//  4 Backpressure: 12 items streaming, OUT_FULL_N=0 cycles 3..10 -> no ENQ while
//    low, IN_DEQ drops after the 7th item, 3 words out in order, none lost or duped.
//  5 Throughput: 16 items, OUT_FULL_N=1 -> 16 consecutive IN_DEQ cycles, 4 ENQs
//    spaced exactly 4 cycles apart.
//  6 Mid-word CLR: 2 items in then CLR=1 for 1 cycle -> out_valid=0, next 4 items
//    0x01..0x04 give OUT_D=32'h04030201; RST_N=0 mid-word behaves the same.

Source files
------------

// File: rtl/pack_out_reg.sv
// One-entry holding register for a packed wide word: load, drain and flush
// with a valid flag. Load wins over drain so back-to-back words sustain rate.
module pack_out_reg #(
   parameter int unsigned dWidth = 32,
   parameter int unsigned cWidth = 3
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              CLR,
   input  logic              LOAD,
   input  logic              DRAIN,
   input  logic [dWidth-1:0] LOAD_D,
   input  logic [cWidth-1:0] LOAD_CNT,
   input  logic              LOAD_LAST,
   output logic              VALID,
   output logic [dWidth-1:0] Q_D,
   output logic [cWidth-1:0] Q_CNT,
   output logic              Q_LAST
);

   always_ff @(posedge CLK) begin
      if (!RST_N || CLR) begin
         VALID  <= 1'b0;
         Q_D    <= '0;
         Q_CNT  <= '0;
         Q_LAST <= 1'b0;
      end else if (LOAD) begin
         VALID  <= 1'b1;
         Q_D    <= LOAD_D;
         Q_CNT  <= LOAD_CNT;
         Q_LAST <= LOAD_LAST;
      end else if (DRAIN) begin
         VALID  <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_width_packer.sv
// Upsizer between a narrow depth-1 FIFO and a wide FIFO: packs ratio items per
// word, IN_LAST closes a partial word early with zero-filled upper lanes.
module fifo_width_packer #(
   parameter int unsigned inWidth  = 8,
   parameter int unsigned ratio    = 4,
   parameter int unsigned cntWidth = 3
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic                      CLR,
   input  logic [inWidth-1:0]        IN_D,
   input  logic                      IN_LAST,
   input  logic                      IN_EMPTY_N,
   output logic                      IN_DEQ,
   output logic [inWidth*ratio-1:0]  OUT_D,
   output logic [cntWidth-1:0]       OUT_CNT,
   output logic                      OUT_LAST,
   input  logic                      OUT_FULL_N,
   output logic                      OUT_ENQ
);

   localparam int unsigned outWidth = inWidth * ratio;
   localparam int unsigned accWidth = outWidth - inWidth;
   localparam logic [cntWidth-1:0] lastIdx = cntWidth'(ratio - 1);

   logic [cntWidth-1:0] idx_q, idx_d;
   logic [accWidth-1:0] acc_q, acc_d;
   logic                flush, out_valid, close, drain, load;
   logic [outWidth-1:0] word;
   logic [cntWidth-1:0] word_cnt;

   // Flush also gates the handshakes so nothing is consumed or emitted while clearing.
   assign flush   = !RST_N || CLR;
   assign drain   = !flush && out_valid && OUT_FULL_N;
   assign OUT_ENQ = drain;
   assign close   = (idx_q == lastIdx) || IN_LAST;
   assign IN_DEQ  = !flush && IN_EMPTY_N && (!close || !out_valid || drain);
   assign load    = IN_DEQ && close;
   assign word_cnt = idx_q + 1'b1;

   always_comb begin
      word = '0;
      for (int k = 0; k < int'(ratio) - 1; k++) begin
         if (cntWidth'(k) < idx_q) word[k*inWidth +: inWidth] = acc_q[k*inWidth +: inWidth];
      end
      word[idx_q*inWidth +: inWidth] = IN_D;
   end

   always_comb begin
      acc_d = acc_q;
      idx_d = idx_q;
      if (IN_DEQ) begin
         if (close) begin
            acc_d = '0;
            idx_d = '0;
         end else begin
            acc_d[idx_q*inWidth +: inWidth] = IN_D;
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (flush) begin
         idx_q <= '0;
         acc_q <= '0;
      end else begin
         idx_q <= idx_d;
         acc_q <= acc_d;
      end
   end

   pack_out_reg #(
      .dWidth (outWidth),
      .cWidth (cntWidth)
   ) u_out_reg (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .CLR       (CLR),
      .LOAD      (load),
      .DRAIN     (drain),
      .LOAD_D    (word),
      .LOAD_CNT  (word_cnt),
      .LOAD_LAST (IN_LAST),
      .VALID     (out_valid),
      .Q_D       (OUT_D),
      .Q_CNT     (OUT_CNT),
      .Q_LAST    (OUT_LAST)
   );

`ifndef SYNTHESIS
   always @(posedge CLK) begin
      assert (!(IN_DEQ && !IN_EMPTY_N));
      assert (!(OUT_ENQ && !OUT_FULL_N));
   end
`endif

endmodule

// File: tb/tb_fifo_width_packer.sv
// Bench for fifo_width_packer: upstream FIFO model feeding items, packing model
// pushing expected words, compared as the DUT enqueues them.
module tb_fifo_width_packer;

   logic        CLK = 1'b0;
   logic        RST_N, CLR, IN_LAST, IN_EMPTY_N, IN_DEQ, OUT_LAST, OUT_FULL_N, OUT_ENQ;
   logic [7:0]  IN_D;
   logic [31:0] OUT_D;
   logic [2:0]  OUT_CNT;

   typedef struct packed {
      logic [31:0] d;
      logic [2:0]  cnt;
      logic        last;
   } word_t;

   word_t       exp_q[$];
   logic [7:0]  src_d[$];
   logic        src_last[$];
   logic [31:0] m_acc;
   int          m_idx;
   int          n_checks;
   int          n_fail;

   always #5 CLK = ~CLK;

   fifo_width_packer #(
      .inWidth  (8),
      .ratio    (4),
      .cntWidth (3)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .CLR        (CLR),
      .IN_D       (IN_D),
      .IN_LAST    (IN_LAST),
      .IN_EMPTY_N (IN_EMPTY_N),
      .IN_DEQ     (IN_DEQ),
      .OUT_D      (OUT_D),
      .OUT_CNT    (OUT_CNT),
      .OUT_LAST   (OUT_LAST),
      .OUT_FULL_N (OUT_FULL_N),
      .OUT_ENQ    (OUT_ENQ)
   );

   task automatic push_item(input logic [7:0] d, input logic last);
      src_d.push_back(d);
      src_last.push_back(last);
      m_acc[m_idx*8 +: 8] = d;
      if (m_idx == 3 || last) begin
         exp_q.push_back('{d: m_acc, cnt: 3'(m_idx + 1), last: last});
         m_acc = '0;
         m_idx = 0;
      end else begin
         m_idx++;
      end
   endtask

   task automatic model_flush();
      src_d.delete();
      src_last.delete();
      exp_q.delete();
      m_acc = '0;
      m_idx = 0;
   endtask

   // Drives one cycle from the upstream model, samples outputs 1 unit after negedge.
   task automatic cycle(input logic full_n, input logic clr, input logic rst_n,
                        output logic deq, output logic enq, output word_t w);
      @(negedge CLK);
      CLR        = clr;
      RST_N      = rst_n;
      OUT_FULL_N = full_n;
      IN_EMPTY_N = (src_d.size() > 0);
      IN_D       = (src_d.size() > 0) ? src_d[0] : 8'hEE;
      IN_LAST    = (src_d.size() > 0) ? src_last[0] : 1'b0;
      #1;
      deq = IN_DEQ;
      enq = OUT_ENQ;
      w   = '{d: OUT_D, cnt: OUT_CNT, last: OUT_LAST};
      if (deq && src_d.size() > 0) begin
         void'(src_d.pop_front());
         void'(src_last.pop_front());
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0; CLR = 1'b0; IN_EMPTY_N = 1'b1; IN_D = 8'h5A; IN_LAST = 1'b0;
      OUT_FULL_N = 1'b1;
      repeat (3) begin
         @(negedge CLK); #1;
         n_checks++;
         if (IN_DEQ !== 1'b0) begin n_fail++; $display("FAIL reset IN_DEQ got %b want 0", IN_DEQ); end
         n_checks++;
         if (OUT_ENQ !== 1'b0) begin n_fail++; $display("FAIL reset OUT_ENQ got %b want 0", OUT_ENQ); end
         n_checks++;
         if (OUT_CNT !== 3'd0) begin n_fail++; $display("FAIL reset OUT_CNT got %0d want 0", OUT_CNT); end
         n_checks++;
         if (OUT_D !== 32'h0 || OUT_LAST !== 1'b0) begin
            n_fail++; $display("FAIL reset OUT_D/LAST got %h/%b want 0/0", OUT_D, OUT_LAST);
         end
      end
   endtask

   task automatic test_full_word();
      logic deq, enq; word_t w, e;
      int n_deq = 0, n_enq = 0, deq4_cyc = -10, enq_cyc = -1;
      push_item(8'h11, 1'b0); push_item(8'h22, 1'b0);
      push_item(8'h33, 1'b0); push_item(8'h44, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b0, 1'b1, deq, enq, w);
         if (deq) begin n_deq++; if (n_deq == 4) deq4_cyc = i; end
         if (enq) begin
            n_enq++; enq_cyc = i;
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL full_word extra enq d=%h", w.d); end
            else begin
               e = exp_q.pop_front();
               if (w !== e) begin
                  n_fail++;
                  $display("FAIL full_word word got %h/%0d/%b want %h/%0d/%b",
                           w.d, w.cnt, w.last, e.d, e.cnt, e.last);
               end
            end
            n_checks++;
            if (w.d !== 32'h44332211 || w.cnt !== 3'd4 || w.last !== 1'b0) begin
               n_fail++; $display("FAIL full_word literal got %h/%0d/%b want 44332211/4/0",
                                  w.d, w.cnt, w.last);
            end
         end
      end
      n_checks++;
      if (n_enq != 1) begin n_fail++; $display("FAIL full_word enq count got %0d want 1", n_enq); end
      n_checks++;
      if (enq_cyc != deq4_cyc + 1) begin
         n_fail++; $display("FAIL full_word latency got enq %0d want %0d", enq_cyc, deq4_cyc + 1);
      end
   endtask

   task automatic test_partial();
      logic deq, enq; word_t w, e;
      int n_enq = 0;
      push_item(8'hA1, 1'b0); push_item(8'hB2, 1'b1);
      push_item(8'h01, 1'b0); push_item(8'h02, 1'b0);
      push_item(8'h03, 1'b0); push_item(8'h04, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b0, 1'b1, deq, enq, w);
         if (enq) begin
            n_enq++;
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL partial extra enq d=%h", w.d); end
            else begin
               e = exp_q.pop_front();
               if (w !== e) begin
                  n_fail++;
                  $display("FAIL partial word got %h/%0d/%b want %h/%0d/%b",
                           w.d, w.cnt, w.last, e.d, e.cnt, e.last);
               end
            end
            n_checks++;
            if (n_enq == 1 && (w.d !== 32'h0000B2A1 || w.cnt !== 3'd2 || w.last !== 1'b1)) begin
               n_fail++; $display("FAIL partial first got %h/%0d/%b want 0000b2a1/2/1",
                                  w.d, w.cnt, w.last);
            end else if (n_enq == 2 && (w.d !== 32'h04030201 || w.cnt !== 3'd4)) begin
               n_fail++; $display("FAIL partial restart got %h/%0d want 04030201/4", w.d, w.cnt);
            end
         end
      end
      n_checks++;
      if (n_enq != 2) begin n_fail++; $display("FAIL partial enq count got %0d want 2", n_enq); end
   endtask

   task automatic test_backpressure();
      logic deq, enq, full_n, had_item; word_t w, e;
      int n_deq = 0, n_enq = 0, stall_at = -1;
      for (int i = 0; i < 12; i++) push_item(8'h30 + 8'(i), 1'b0);
      for (int c = 1; c <= 20; c++) begin
         full_n = !(c >= 3 && c <= 10);
         had_item = (src_d.size() > 0);
         cycle(full_n, 1'b0, 1'b1, deq, enq, w);
         if (deq) n_deq++;
         if (!deq && had_item && stall_at < 0) stall_at = n_deq;
         if (!full_n) begin
            n_checks++;
            if (enq !== 1'b0) begin n_fail++; $display("FAIL backpressure enq while full cyc %0d", c); end
         end
         if (enq) begin
            n_enq++;
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL backpressure extra enq d=%h", w.d); end
            else begin
               e = exp_q.pop_front();
               if (w !== e) begin
                  n_fail++;
                  $display("FAIL backpressure word got %h/%0d/%b want %h/%0d/%b",
                           w.d, w.cnt, w.last, e.d, e.cnt, e.last);
               end
            end
         end
      end
      n_checks++;
      if (stall_at != 7) begin n_fail++; $display("FAIL backpressure stall after %0d items want 7", stall_at); end
      n_checks++;
      if (n_enq != 3 || exp_q.size() != 0 || src_d.size() != 0) begin
         n_fail++; $display("FAIL backpressure totals enq %0d left exp %0d src %0d want 3/0/0",
                            n_enq, exp_q.size(), src_d.size());
      end
   endtask

   task automatic test_throughput();
      logic deq, enq; word_t w, e;
      int n_deq16 = 0, n_enq = 0, prev_enq = -1, bad_gap = 0;
      for (int i = 0; i < 16; i++) push_item(8'h80 + 8'(i), 1'b0);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 1'b0, 1'b1, deq, enq, w);
         if (i < 16 && deq) n_deq16++;
         if (enq) begin
            n_enq++;
            if (prev_enq >= 0 && i - prev_enq != 4) bad_gap++;
            prev_enq = i;
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL throughput extra enq d=%h", w.d); end
            else begin
               e = exp_q.pop_front();
               if (w !== e) begin
                  n_fail++;
                  $display("FAIL throughput word got %h/%0d/%b want %h/%0d/%b",
                           w.d, w.cnt, w.last, e.d, e.cnt, e.last);
               end
            end
         end
      end
      n_checks++;
      if (n_deq16 != 16) begin n_fail++; $display("FAIL throughput deq cycles got %0d want 16", n_deq16); end
      n_checks++;
      if (n_enq != 4 || bad_gap != 0) begin
         n_fail++; $display("FAIL throughput enq count %0d bad gaps %0d want 4/0", n_enq, bad_gap);
      end
   endtask

   task automatic test_clear(input logic use_rst);
      logic deq, enq; word_t w, e;
      int n_enq = 0;
      // A closed word is held (downstream full) and two more items sit in the accumulator.
      push_item(8'hD0, 1'b1); push_item(8'hE1, 1'b0); push_item(8'hE2, 1'b0);
      repeat (3) cycle(1'b0, 1'b0, 1'b1, deq, enq, w);
      model_flush();
      cycle(1'b1, !use_rst, !use_rst, deq, enq, w);
      n_checks++;
      if (deq !== 1'b0 || enq !== 1'b0) begin
         n_fail++; $display("FAIL clear(%0b) during flush deq/enq got %b/%b want 0/0", use_rst, deq, enq);
      end
      cycle(1'b1, 1'b0, 1'b1, deq, enq, w);
      n_checks++;
      if (enq !== 1'b0 || w.cnt !== 3'd0) begin
         n_fail++; $display("FAIL clear(%0b) after flush enq/cnt got %b/%0d want 0/0", use_rst, enq, w.cnt);
      end
      for (int i = 1; i <= 4; i++) push_item(8'(i), 1'b0);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b0, 1'b1, deq, enq, w);
         if (enq) begin
            n_enq++;
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL clear(%0b) extra enq d=%h", use_rst, w.d); end
            else begin
               e = exp_q.pop_front();
               if (w !== e || w.d !== 32'h04030201) begin
                  n_fail++;
                  $display("FAIL clear(%0b) word got %h/%0d/%b want %h/%0d/%b",
                           use_rst, w.d, w.cnt, w.last, e.d, e.cnt, e.last);
               end
            end
         end
      end
      n_checks++;
      if (n_enq != 1) begin n_fail++; $display("FAIL clear(%0b) enq count got %0d want 1", use_rst, n_enq); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m_acc    = '0;
      m_idx    = 0;
      test_reset();
      test_full_word();
      test_partial();
      test_backpressure();
      test_throughput();
      test_clear(1'b0);
      test_clear(1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
